// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master / two-slave read interconnect for the NPC core.
// One transaction in flight at a time. Masters are granted round-robin, and the
// granted address is routed to either main memory (s0) or the CLINT (s1).
// Addresses outside both regions are answered locally with rresp=1.
module axi_rd_arbiter #(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_MASK   = 32'hF800_0000,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (IFU)
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // master 1 (LSU)
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // slave 0 (main memory)
  output logic [31:0] s0_araddr,
  output logic        s0_arvalid,
  input  logic        s0_arready,
  input  logic [31:0] s0_rdata,
  input  logic        s0_rresp,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  // slave 1 (CLINT)
  output logic [31:0] s1_araddr,
  output logic        s1_arvalid,
  input  logic        s1_arready,
  input  logic [31:0] s1_rdata,
  input  logic        s1_rresp,
  input  logic        s1_rvalid,
  output logic        s1_rready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_target;
  logic [31:0] r_addr_q;
  logic        r_last;

  logic        w_any_req;
  logic        w_winner;
  logic [31:0] w_win_addr;
  logic        w_clint_hit;
  logic        w_mem_hit;
  logic        w_s_arready;
  logic        w_s_rvalid;
  logic [31:0] w_s_rdata;
  logic        w_s_rresp;
  logic        w_m_rready;

  // Round-robin winner: a lone requester wins; on contention the master that
  // was not granted last time wins.
  assign w_any_req  = m0_arvalid | m1_arvalid;
  assign w_winner   = (m0_arvalid && m1_arvalid) ? ~r_last : m1_arvalid;
  assign w_win_addr = w_winner ? m1_araddr : m0_araddr;

  // Address decode of the winning request; CLINT is checked first.
  assign w_clint_hit = ((w_win_addr & CLINT_MASK) == CLINT_BASE);
  assign w_mem_hit   = ((w_win_addr & MEM_MASK) == MEM_BASE);

  // Selected slave / owning master views used by the handshakes.
  assign w_s_arready = r_target ? s1_arready : s0_arready;
  assign w_s_rvalid  = r_target ? s1_rvalid  : s0_rvalid;
  assign w_s_rdata   = r_target ? s1_rdata   : s0_rdata;
  assign w_s_rresp   = r_target ? s1_rresp   : s0_rresp;
  assign w_m_rready  = r_owner  ? m1_rready  : m0_rready;

  // Output steering: every port defaults to 0 and only the selected path is driven.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; an incomplete assignment in always_comb infers a latch.
    m0_arready = 1'b0;
    m0_rdata   = 32'h0;
    m0_rresp   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = 32'h0;
    m1_rresp   = 1'b0;
    m1_rvalid  = 1'b0;
    s0_araddr  = 32'h0;
    s0_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_araddr  = 32'h0;
    s1_arvalid = 1'b0;
    s1_rready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          if (w_winner) m1_arready = 1'b1;
          else          m0_arready = 1'b1;
        end
      end
      ADDR: begin
        if (r_target) begin
          s1_arvalid = 1'b1;
          s1_araddr  = r_addr_q;
        end else begin
          s0_arvalid = 1'b1;
          s0_araddr  = r_addr_q;
        end
      end
      DATA: begin
        if (r_owner) begin
          m1_rvalid = w_s_rvalid;
          m1_rdata  = w_s_rdata;
          m1_rresp  = w_s_rresp;
        end else begin
          m0_rvalid = w_s_rvalid;
          m0_rdata  = w_s_rdata;
          m0_rresp  = w_s_rresp;
        end
        if (r_target) s1_rready = w_m_rready;
        else          s0_rready = w_m_rready;
      end
      ERR: begin
        if (r_owner) begin
          m1_rvalid = 1'b1;
          m1_rresp  = 1'b1;
        end else begin
          m0_rvalid = 1'b1;
          m0_rresp  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM: grant and decode in IDLE, then address and data phases.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_target <= 1'b0;
      r_addr_q <= 32'h0;
      r_last   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner  <= w_winner;
            r_last   <= w_winner;
            r_addr_q <= w_win_addr;
            if (w_clint_hit) begin
              r_target <= 1'b1;
              r_state  <= ADDR;
            end else if (w_mem_hit) begin
              r_target <= 1'b0;
              r_state  <= ADDR;
            end else begin
              r_state  <= ERR;
            end
          end
        end
        ADDR: if (w_s_arready) r_state <= DATA;
        DATA: if (w_s_rvalid && w_m_rready) r_state <= IDLE;
        ERR:  if (w_m_rready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well before the next rising edge.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic        m0_arready, m1_arready, m0_rresp, m1_rresp, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata;
  logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready;
  logic        s0_arready, s1_arready, s0_rresp, s1_rresp, s0_rvalid, s1_rvalid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // Both masters hold arvalid; expect exp_owner to be granted and served by s0.
  task automatic serve_s0(input logic exp_owner, input logic [31:0] exp_addr,
                          input logic [31:0] data);
    settle();
    check("rr_arready_win",  exp_owner ? m1_arready : m0_arready, 1);
    check("rr_arready_lose", exp_owner ? m0_arready : m1_arready, 0);
    step();
    settle();
    check("rr_s0_arvalid", s0_arvalid, 1);
    check("rr_s0_araddr",  s0_araddr, exp_addr);
    check("rr_no_arready_addr", {31'h0, m0_arready | m1_arready}, 0);
    step();
    s0_rvalid = 1'b1;
    s0_rdata  = data;
    settle();
    check("rr_owner_rvalid", exp_owner ? m1_rvalid : m0_rvalid, 1);
    check("rr_owner_rdata",  exp_owner ? m1_rdata  : m0_rdata, data);
    check("rr_other_rvalid", exp_owner ? m0_rvalid : m1_rvalid, 0);
    step();
    s0_rvalid = 1'b0;
    s0_rdata  = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    m0_araddr = 0; m1_araddr = 0; m0_arvalid = 0; m1_arvalid = 0;
    m0_rready = 0; m1_rready = 0;
    s0_arready = 0; s1_arready = 0; s0_rdata = 0; s1_rdata = 0;
    s0_rresp = 0; s1_rresp = 0; s0_rvalid = 0; s1_rvalid = 0;
    step(); step();
    settle();
    check("rst_m0_arready", m0_arready, 0);
    check("rst_m0_rvalid",  m0_rvalid, 0);
    check("rst_m1_rvalid",  m1_rvalid, 0);
    check("rst_s0_arvalid", s0_arvalid, 0);
    check("rst_s1_arvalid", s1_arvalid, 0);
    check("rst_s0_araddr",  s0_araddr, 0);
    rst = 1'b0;
    step();

    // ---- m0 reads CLINT; stray s1_rvalid in IDLE is ignored first ----
    s1_rvalid = 1'b1;
    settle();
    check("idle_s1_rready", s1_rready, 0);
    check("idle_m0_rvalid", m0_rvalid, 0);
    s1_rvalid = 1'b0;
    m0_arvalid = 1'b1; m0_araddr = 32'h0200_0000; s1_arready = 1'b1;
    settle();
    check("clint_m0_arready", m0_arready, 1);
    check("clint_m1_arready", m1_arready, 0);
    step();
    m0_arvalid = 1'b0; m0_araddr = 32'h0;
    settle();
    check("clint_s1_arvalid", s1_arvalid, 1);
    check("clint_s1_araddr",  s1_araddr, 32'h0200_0000);
    check("clint_s0_arvalid", s0_arvalid, 0);
    step();
    s1_rvalid = 1'b1; s1_rdata = 32'h1234_5678; s1_rresp = 1'b0; m0_rready = 1'b1;
    settle();
    check("clint_m0_rvalid", m0_rvalid, 1);
    check("clint_m0_rdata",  m0_rdata, 32'h1234_5678);
    check("clint_m0_rresp",  m0_rresp, 0);
    check("clint_m1_rvalid", m1_rvalid, 0);
    check("clint_s1_rready", s1_rready, 1);
    check("clint_s0_arvalid_data", s0_arvalid, 0);
    step();
    s1_rvalid = 1'b0; s1_rdata = 32'h0; s1_arready = 1'b0;
    settle();
    check("clint_done_rvalid", m0_rvalid, 0);

    // ---- reset while in DATA; then contention must favour m0 ----
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0010; s0_arready = 1'b1; m0_rready = 1'b1;
    step();
    m0_arvalid = 1'b0;
    step();
    settle();
    check("rstmid_s0_rready_data", s0_rready, 1);
    rst = 1'b1;
    step();
    s0_rvalid = 1'b1;
    settle();
    check("rstmid_m0_rvalid",  m0_rvalid, 0);
    check("rstmid_m1_rvalid",  m1_rvalid, 0);
    check("rstmid_s0_arvalid", s0_arvalid, 0);
    check("rstmid_s0_rready",  s0_rready, 0);
    s0_rvalid = 1'b0;
    rst = 1'b0;
    step();

    // ---- contention after reset: alternation m0, m1, m0, m1 ----
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_0004;
    m0_rready = 1'b1; m1_rready = 1'b1;
    serve_s0(1'b0, 32'h8000_0000, 32'hA000_0000);
    serve_s0(1'b1, 32'h8000_0004, 32'hA000_0001);
    serve_s0(1'b0, 32'h8000_0000, 32'hA000_0002);
    serve_s0(1'b1, 32'h8000_0004, 32'hA000_0003);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; s0_arready = 1'b0;

    // ---- m1 unmapped address: local error response, held under backpressure ----
    m1_arvalid = 1'b1; m1_araddr = 32'h1000_0000; m1_rready = 1'b0;
    settle();
    check("err_m1_arready", m1_arready, 1);
    step();
    m1_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("err_m1_rvalid", m1_rvalid, 1);
      check("err_m1_rdata",  m1_rdata, 0);
      check("err_m1_rresp",  m1_rresp, 1);
      check("err_no_slave",  {30'h0, s1_arvalid, s0_arvalid}, 0);
      step();
    end
    m1_rready = 1'b1;
    settle();
    check("err_release_rvalid", m1_rvalid, 1);
    step();
    settle();
    check("err_idle_rvalid", m1_rvalid, 0);

    // ---- backpressure on s0 address and m0 data; m1 request withdrawn ----
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0100; s0_arready = 1'b0; m0_rready = 1'b0;
    settle();
    check("bp_m0_arready", m0_arready, 1);
    step();
    m0_arvalid = 1'b0; m0_araddr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) m1_arvalid = 1'b1;
      if (i == 2) m1_arvalid = 1'b0;
      settle();
      check("bp_s0_arvalid", s0_arvalid, 1);
      check("bp_s0_araddr",  s0_araddr, 32'h8000_0100);
      check("bp_m1_arready", m1_arready, 0);
      step();
    end
    s0_arready = 1'b1;
    settle();
    check("bp_s0_arvalid_acc", s0_arvalid, 1);
    step();
    s0_arready = 1'b0; s0_rvalid = 1'b1; s0_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_s0_rready_low", s0_rready, 0);
      check("bp_m0_rdata_hold", m0_rdata, 32'h5555_AAAA);
      check("bp_m0_rvalid",     m0_rvalid, 1);
      step();
    end
    m0_rready = 1'b1;
    settle();
    check("bp_s0_rready_high", s0_rready, 1);
    step();
    s0_rvalid = 1'b0; s0_rdata = 32'h0;
    settle();
    check("bp_done_rvalid",  m0_rvalid, 0);
    check("bp_done_arvalid", s0_arvalid, 0);
    step();
    settle();
    check("bp_no_reissue", {30'h0, s1_arvalid, s0_arvalid}, 0);

    // ---- slave error passed through unchanged ----
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0200; s0_arready = 1'b1;
    step();
    m0_arvalid = 1'b0;
    step();
    s0_rvalid = 1'b1; s0_rdata = 32'hDEAD_BEEF; s0_rresp = 1'b1;
    settle();
    check("serr_m0_rresp", m0_rresp, 1);
    check("serr_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("serr_m1_rresp", m1_rresp, 0);
    step();
    s0_rvalid = 1'b0; s0_rresp = 1'b0; s0_rdata = 32'h0;
    settle();
    check("serr_done", m0_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
